ctrl_decode_stage: RTL
======================

// Module: ctrl_decode_stage
// PURPOSE
//  Parametrised successor to the single-opcode control decoder. Decodes the full 32-bit instruction
//  (opcode/funct3/funct7) and generates immediates. Registers the control bundle into the ID/EX
//  pipeline register with valid/ready, flush and load-use hazard stall.
//  Sits between the IF/ID register and the execute stage of the 3-stage core.
// PARAMETERS
//  XLEN        32  datapath width; immediates sign-extended to XLEN
//  ALU_OP_W    4   ALU op code width (ctrl_pkg::alu_op_t)
//  EN_JUMP     1   1: decode JAL/JALR/LUI/AUIPC; 0: those opcodes are illegal
//  STALL_CNT_W 16  width of saturating hazard-stall performance counter
// PORTS
//  clk          in   1         rising-edge clock
//  rst_n        in   1         asynchronous active-low reset
//  if_valid     in   1         instr holds a valid instruction
//  if_ready     out  1         stage accepts instr this cycle (= ~hazard)
//  instr        in   32        instruction from IF/ID
//  flush        in   1         branch/jump redirect: kill ID/EX contents
//  ex_valid     out  1         ID/EX register holds a real instruction
//  ex_ctrl      out  struct    ctrl_pkg::ctrl_t: reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump, alu_op
//  ex_rs1/rs2/rd out 5 each    register addresses
//  ex_funct3    out  3         funct3 passthrough (branch compare, load/store size)
//  ex_imm       out  XLEN      sign-extended immediate
//  ex_illegal   out  1         instruction decoded as illegal
//  stall_cnt    out  STALL_CNT_W  count of hazard-stall cycles, saturating
// BEHAVIOUR
//  - Reset (async, rst_n=0): ex_valid=0, ex_ctrl=all 0 with alu_op=ALU_NOP (all ones).
//    ex_rs1/rs2/rd/funct3/imm=0, ex_illegal=0, stall_cnt=0. Takes effect immediately, mid-operation included.
//  - Decode is combinational; outputs appear 1 cycle after acceptance (if_valid & if_ready at edge).
//  - Opcodes:
//    R 0110011: reg_write, alu_op from funct3/funct7[5].
//    I 0010011: reg_write, alu_src, alu_op from funct3; SRAI via funct7[5].
//    Load 0000011: reg_write, mem_read, mem_to_reg, alu_src, ALU_ADD.
//    Store 0100011: mem_write, alu_src, ALU_ADD.
//    Branch 1100011: branch, ALU_SUB.
//    EN_JUMP only:
//      JAL 1101111 / JALR 1100111: jump, reg_write; JALR also alu_src, ALU_ADD.
//      LUI 0110111: reg_write, alu_src, ALU_PASSB.
//      AUIPC 0010111: reg_write, alu_src, ALU_ADD.
//  - Immediates: I/S/B/U/J formats per RV32I. Sign bit is instr[31]; B/J LSB=0; U low 12 bits=0; R-type imm=0.
//  - Illegal (unknown opcode, or R-type funct7 not 0000000/0100000): ex_valid=1, ex_illegal=1,
//    all write/mem/branch/jump enables 0, alu_op=ALU_NOP.
//  - Load-use hazard (combinational):
//    ex_valid & ex_ctrl.mem_read & ex_rd!=0 & if_valid &
//    ((rs1_used & rs1==ex_rd) | (rs2_used & rs2==ex_rd)).
//    rs1_used: R,I,Load,Store,Branch,JALR. rs2_used: R,Store,Branch.
//    On hazard: if_ready=0, next cycle ID/EX = bubble (ex_valid=0, ctrl as reset), stall_cnt+=1.
//    Exactly one bubble per load-use pair.
//  - Priority at a clock edge: flush > hazard > accept > idle.
//    Flush: ID/EX <= bubble regardless of if_valid/hazard; stall_cnt not incremented.
//    Idle (if_valid=0, no flush): ID/EX <= bubble.
//  - stall_cnt saturates at all ones, never wraps.
//  - if_ready does not depend on flush (no combinational path flush->if_ready).
// STRUCTURE
//  - ctrl_pkg: opcode localparams, alu_op_t enum (ALU_ADD, SUB, AND, OR, XOR, SLL, SRL, SRA,
//    SLT, SLTU, PASSB, NOP=all ones), ctrl_t packed struct, CTRL_BUBBLE constant.
//  - Sub-module ctrl_decoder: purely combinational instr -> ctrl_t, imm, rs1/rs2_used, illegal.
//  - Top: hazard detect, priority mux, ID/EX register, stall counter.
// TESTING
//  - Reset mid-stream: rst_n low while ex_valid=1 -> all outputs at reset values immediately.
//    After release, first accepted instr appears 1 cycle later.
//  - 0x002081B3 (add x3,x1,x2) -> next cycle ex_valid=1, reg_write=1, alu_op=ALU_ADD, rd=3, rs1=1, rs2=2, imm=0.
//  - 0x0000A283 (lw x5,0(x1)) then 0x00528333 (add x6,x5,x5):
//    if_ready=0 one cycle, one bubble, add issues next, stall_cnt=1.
//  - 0xFE000EE3 (beq x0,x0,-4) -> branch=1, ALU_SUB, imm=0xFFFFFFFC.
//    flush asserted same cycle as a hazard -> bubble, stall_cnt unchanged.
//  - 0xFFFFFFFF -> ex_illegal=1, ex_valid=1, all enables 0.
//    EN_JUMP=0 with 0x008000EF (jal) -> ex_illegal=1.
//  - Force stall_cnt to all ones, trigger another hazard -> stall_cnt stays all ones.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the ID stage: opcodes, ALU op encoding and the control bundle
// carried in the ID/EX pipeline register.
package ctrl_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = '0,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU,
    ALU_PASSB,
    ALU_NOP = '1
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    jump;
    alu_op_t alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    mem_to_reg: 1'b0,
    alu_src:    1'b0,
    branch:     1'b0,
    jump:       1'b0,
    alu_op:     ALU_NOP
  };

  // SUB only exists in the register form; SRA is selected by funct7[5] in both forms.
  function automatic alu_op_t alu_from_funct(input logic [2:0] f3, input logic f7b5,
                                             input logic is_reg);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// IF/ID -> ID/EX handshake bundle. master = instruction source side, slave = decode stage.
interface ctrl_decode_stage_if #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
);
  import ctrl_pkg::*;

  logic                   if_valid;
  logic                   if_ready;
  logic [31:0]            instr;
  logic                   flush;
  logic                   ex_valid;
  ctrl_t                  ex_ctrl;
  logic [4:0]             ex_rs1;
  logic [4:0]             ex_rs2;
  logic [4:0]             ex_rd;
  logic [2:0]             ex_funct3;
  logic [XLEN-1:0]        ex_imm;
  logic                   ex_illegal;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output if_valid, instr, flush,
    input  if_ready, ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_imm,
           ex_illegal, stall_cnt
  );

  modport slave (
    input  if_valid, instr, flush,
    output if_ready, ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_imm,
           ex_illegal, stall_cnt
  );

endinterface

// File: rtl/ctrl_decoder.sv
// Purely combinational RV32I decoder: control bundle, immediate, source-register usage
// and illegal-instruction flag.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int EN_JUMP = 1
) (
  input  logic [31:0]     i_instr,
  output ctrl_t           o_ctrl,
  output logic [XLEN-1:0] o_imm,
  output logic            o_rs1_used,
  output logic            o_rs2_used,
  output logic            o_illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];

  assign w_imm_i = XLEN'($signed(i_instr[31:20]));
  assign w_imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
  assign w_imm_b = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'h000}));
  assign w_imm_j = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));

  always_comb begin
    // NOTE: every output gets a default first so no decode path can infer a latch.
    o_ctrl     = CTRL_BUBBLE;
    o_imm      = '0;
    o_rs1_used = 1'b0;
    o_rs2_used = 1'b0;
    o_illegal  = 1'b0;

    case (w_opcode)
      OP_R: begin
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b1;
        if (w_funct7 == 7'b0000000 || w_funct7 == 7'b0100000) begin
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = alu_from_funct(w_funct3, w_funct7[5], 1'b1);
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_I: begin
        o_rs1_used       = 1'b1;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = alu_from_funct(w_funct3, w_funct7[5], 1'b0);
        o_imm            = w_imm_i;
      end
      OP_LOAD: begin
        o_rs1_used        = 1'b1;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.alu_op     = ALU_ADD;
        o_imm             = w_imm_i;
      end
      OP_STORE: begin
        o_rs1_used       = 1'b1;
        o_rs2_used       = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = ALU_ADD;
        o_imm            = w_imm_s;
      end
      OP_BRANCH: begin
        o_rs1_used    = 1'b1;
        o_rs2_used    = 1'b1;
        o_ctrl.branch = 1'b1;
        o_ctrl.alu_op = ALU_SUB;
        o_imm         = w_imm_b;
      end
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
        if (EN_JUMP != 0) begin
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALU_ADD;
          case (w_opcode)
            OP_JAL: begin
              o_ctrl.jump = 1'b1;
              o_imm       = w_imm_j;
            end
            OP_JALR: begin
              o_rs1_used     = 1'b1;
              o_ctrl.jump    = 1'b1;
              o_ctrl.alu_src = 1'b1;
              o_imm          = w_imm_i;
            end
            OP_LUI: begin
              o_ctrl.alu_src = 1'b1;
              o_ctrl.alu_op  = ALU_PASSB;
              o_imm          = w_imm_u;
            end
            default: begin
              o_ctrl.alu_src = 1'b1;
              o_imm          = w_imm_u;
            end
          endcase
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// ID stage: load-use hazard detection, flush/hazard/accept priority, ID/EX register
// and a saturating hazard-stall counter.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int EN_JUMP     = 1,
  parameter int STALL_CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  ctrl_decode_stage_if.slave bus
);

  ctrl_t                  w_ctrl;
  logic [XLEN-1:0]        w_imm;
  logic                   w_rs1_used, w_rs2_used, w_illegal;
  logic [4:0]             w_rs1, w_rs2;
  logic                   w_hazard, w_accept;

  logic                   r_valid;
  ctrl_t                  r_ctrl;
  logic [4:0]             r_rs1, r_rs2, r_rd;
  logic [2:0]             r_funct3;
  logic [XLEN-1:0]        r_imm;
  logic                   r_illegal;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  ctrl_decoder #(
    .XLEN    (XLEN),
    .EN_JUMP (EN_JUMP)
  ) u_decoder (
    .i_instr    (bus.instr),
    .o_ctrl     (w_ctrl),
    .o_imm      (w_imm),
    .o_rs1_used (w_rs1_used),
    .o_rs2_used (w_rs2_used),
    .o_illegal  (w_illegal)
  );

  assign w_rs1 = bus.instr[19:15];
  assign w_rs2 = bus.instr[24:20];

  // Flush is deliberately kept out of the hazard term so if_ready has no path from flush.
  assign w_hazard = r_valid & r_ctrl.mem_read & (r_rd != 5'd0) & bus.if_valid &
                    ((w_rs1_used & (w_rs1 == r_rd)) | (w_rs2_used & (w_rs2 == r_rd)));
  assign w_accept = bus.if_valid & ~w_hazard & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_ctrl      <= CTRL_BUBBLE;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_funct3    <= '0;
      r_imm       <= '0;
      r_illegal   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      // NOTE: non-blocking so the hazard term and the register update all see pre-edge state.
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_ctrl    <= w_ctrl;
        r_rs1     <= w_rs1;
        r_rs2     <= w_rs2;
        r_rd      <= bus.instr[11:7];
        r_funct3  <= bus.instr[14:12];
        r_imm     <= w_imm;
        r_illegal <= w_illegal;
      end else begin
        r_valid   <= 1'b0;
        r_ctrl    <= CTRL_BUBBLE;
        r_rs1     <= '0;
        r_rs2     <= '0;
        r_rd      <= '0;
        r_funct3  <= '0;
        r_imm     <= '0;
        r_illegal <= 1'b0;
      end
      if (w_hazard && !bus.flush && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.if_ready   = ~w_hazard;
  assign bus.ex_valid   = r_valid;
  assign bus.ex_ctrl    = r_ctrl;
  assign bus.ex_rs1     = r_rs1;
  assign bus.ex_rs2     = r_rs2;
  assign bus.ex_rd      = r_rd;
  assign bus.ex_funct3  = r_funct3;
  assign bus.ex_imm     = r_imm;
  assign bus.ex_illegal = r_illegal;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule
